tick_gen: RTL and testbench

TICK_GEN -- requirements
Module: tick_gen

---
 rtl/tick_gen.sv | 104 ++++++++++
 tb/tb_tick_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen.sv
// Programmable tick generator: divides clk by max(period,1) while running and
// drives the in_pulse/enable pair of a downstream digit counter chain.
module tick_gen #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             expire,
    input  logic [WIDTH-1:0] period,
    output logic             tick,
    output logic             running,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_r;
    logic             start_q;
    logic             pause_q;
    logic             clear_q;
    logic             armed;
    logic             start_rise;
    logic             pause_rise;
    logic             clear_rise;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload_val;
    logic [WIDTH-1:0] count_adv;
    logic             count_done;

    // armed stays low for the first edge after reset so a level already high
    // when reset releases is captured as history rather than seen as a rise.
    assign start_rise = armed & start & ~start_q;
    assign pause_rise = armed & pause & ~pause_q;
    assign clear_rise = armed & clear & ~clear_q;

    assign reload_val = (period == '0) ? '0 : period - WIDTH'(1);
    assign count_done = (count == '0);
    assign count_adv  = count_done ? reload_val : count - WIDTH'(1);

    assign running = (state_r == S_RUN);
    assign state   = state_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_IDLE;
            tick    <= 1'b0;
            count   <= '0;
            start_q <= 1'b0;
            pause_q <= 1'b0;
            clear_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            start_q <= start;
            pause_q <= pause;
            clear_q <= clear;
            armed   <= 1'b1;
            tick    <= 1'b0;
            if (clear_rise) begin
                state_r <= S_IDLE;
                count   <= reload_val;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        count <= reload_val;
                        if (start_rise) state_r <= S_RUN;
                    end
                    S_RUN: begin
                        if (expire) begin
                            state_r <= S_DONE;
                        end else if (pause_rise) begin
                            state_r <= S_PAUSED;
                        end else begin
                            count <= count_adv;
                            tick  <= count_done;
                        end
                    end
                    // The resume edge counts as a run cycle, so a pause shifts
                    // the tick schedule by exactly the number of paused edges.
                    S_PAUSED: begin
                        if (expire) begin
                            state_r <= S_DONE;
                        end else if (pause_rise || start_rise) begin
                            state_r <= S_RUN;
                            count   <= count_adv;
                            tick    <= count_done;
                        end
                    end
                    default: begin
                        state_r <= S_DONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: vector table, directed multi-cycle scenarios, and a
// randomized run checked against an elapsed-cycle reference model.
module tb_tick_gen;

    localparam int WIDTH = 26;

    logic             clk    = 1'b0;
    logic             resetn = 1'b0;
    logic             start  = 1'b0;
    logic             pause  = 1'b0;
    logic             clear  = 1'b0;
    logic             expire = 1'b0;
    logic [WIDTH-1:0] period = '0;
    logic             tick;
    logic             running;
    logic [1:0]       state;

    int n_checks = 0;
    int n_fail   = 0;

    tick_gen #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .pause   (pause),
        .clear   (clear),
        .expire  (expire),
        .period  (period),
        .tick    (tick),
        .running (running),
        .state   (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             s;
        logic             p;
        logic             c;
        logic             e;
        logic [WIDTH-1:0] per;
        logic             exp_tick;
        logic [1:0]       exp_state;
    } vec_t;

    vec_t vecs[17];

    // Reference model: counts run edges elapsed in the current interval and
    // ticks when that count reaches the interval length latched at reload.
    int   m_state;
    int   m_elapsed;
    int   m_plen;
    bit   m_tick;
    bit   m_armed;
    bit   m_ps;
    bit   m_pp;
    bit   m_pc;
    logic [2:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic s, input logic p, input logic c, input logic e,
                        input logic [WIDTH-1:0] per);
        @(negedge clk);
        start  = s;
        pause  = p;
        clear  = c;
        expire = e;
        period = per;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        start  = 1'b0;
        pause  = 1'b0;
        clear  = 1'b0;
        expire = 1'b0;
        #1;
        check("reset_tick", 32'(tick), 32'(0));
        check("reset_state", 32'(state), 32'(0));
        check("reset_running", 32'(running), 32'(0));
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_elapsed = 0;
        m_plen    = 1;
        m_tick    = 1'b0;
        m_armed   = 1'b0;
        m_ps      = 1'b0;
        m_pp      = 1'b0;
        m_pc      = 1'b0;
    endtask

    task automatic model_run_edge(input int plen_now);
        m_elapsed++;
        if (m_elapsed >= m_plen) begin
            m_tick    = 1'b1;
            m_elapsed = 0;
            m_plen    = plen_now;
        end
    endtask

    task automatic model_step(input bit s, input bit p, input bit c, input bit e, input int per);
        int  plen_now;
        bit  sr;
        bit  pr;
        bit  cr;
        plen_now = (per == 0) ? 1 : per;
        sr = m_armed && s && !m_ps;
        pr = m_armed && p && !m_pp;
        cr = m_armed && c && !m_pc;
        m_tick = 1'b0;
        if (cr) begin
            m_state = 0;
        end else if (m_state == 0) begin
            if (sr) begin
                m_state   = 1;
                m_elapsed = 0;
                m_plen    = plen_now;
            end
        end else if (m_state == 1) begin
            if (e) m_state = 3;
            else if (pr) m_state = 2;
            else model_run_edge(plen_now);
        end else if (m_state == 2) begin
            if (e) m_state = 3;
            else if (pr || sr) begin
                m_state = 1;
                model_run_edge(plen_now);
            end
        end
        m_ps    = s;
        m_pp    = p;
        m_pc    = c;
        m_armed = 1'b1;
    endtask

    function automatic vec_t mk(input logic s, input logic p, input logic c, input logic e,
                                input logic t, input logic [1:0] st);
        mk = '{s, p, c, e, WIDTH'(2), t, st};
    endfunction

    initial begin
        logic       rs;
        logic       rp;
        logic       rc;
        logic       re;
        logic [WIDTH-1:0] rper;
        logic [2:0] got;

        // Table scenario with period=2: start, tick, pause/resume, expire+pause, DONE, clear.
        vecs[0]  = mk(0, 0, 0, 0, 0, 2'd0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 2'd1);
        vecs[2]  = mk(1, 0, 0, 0, 0, 2'd1);
        vecs[3]  = mk(0, 0, 0, 0, 1, 2'd1);
        vecs[4]  = mk(0, 0, 0, 0, 0, 2'd1);
        vecs[5]  = mk(0, 1, 0, 0, 0, 2'd2);
        vecs[6]  = mk(0, 0, 0, 0, 0, 2'd2);
        vecs[7]  = mk(1, 0, 0, 0, 1, 2'd1);
        vecs[8]  = mk(1, 0, 0, 0, 0, 2'd1);
        vecs[9]  = mk(1, 1, 0, 1, 0, 2'd3);
        vecs[10] = mk(0, 0, 0, 0, 0, 2'd3);
        vecs[11] = mk(1, 1, 0, 0, 0, 2'd3);
        vecs[12] = mk(1, 0, 1, 0, 0, 2'd0);
        vecs[13] = mk(0, 0, 1, 0, 0, 2'd0);
        vecs[14] = mk(1, 0, 0, 0, 0, 2'd1);
        vecs[15] = mk(1, 0, 0, 0, 0, 2'd1);
        vecs[16] = mk(0, 0, 0, 0, 1, 2'd1);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].s, vecs[i].p, vecs[i].c, vecs[i].e, vecs[i].per);
            check($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].exp_tick));
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].exp_state == 2'd1));
        end

        // period=5: ticks exactly after edges N+5, N+10, N+15.
        do_reset();
        step(0, 0, 0, 0, WIDTH'(5));
        step(1, 0, 0, 0, WIDTH'(5));
        check("p5_running_at_start", 32'(running), 32'(1));
        check("p5_tick_at_start", 32'(tick), 32'(0));
        for (int k = 1; k <= 16; k++) begin
            step(0, 0, 0, 0, WIDTH'(5));
            check($sformatf("p5_tick_k%0d", k), 32'(tick), 32'(k % 5 == 0));
            check($sformatf("p5_running_k%0d", k), 32'(running), 32'(1));
        end

        // period 0 and 1 both tick every run cycle.
        for (int pv = 0; pv <= 1; pv++) begin
            do_reset();
            step(0, 0, 0, 0, WIDTH'(pv));
            step(1, 0, 0, 0, WIDTH'(pv));
            check($sformatf("p%0d_tick_start", pv), 32'(tick), 32'(0));
            for (int k = 1; k <= 5; k++) begin
                step(1, 0, 0, 0, WIDTH'(pv));
                check($sformatf("p%0d_tick_k%0d", pv, k), 32'(tick), 32'(1));
            end
        end

        // period=4 with pause rises at edges 2 and 12: next tick after edge 14.
        do_reset();
        step(0, 0, 0, 0, WIDTH'(4));
        step(1, 0, 0, 0, WIDTH'(4));
        for (int k = 1; k <= 16; k++) begin
            step(0, (k == 2 || k == 12), 0, 0, WIDTH'(4));
            check($sformatf("pause_state_k%0d", k), 32'(state), ((k >= 2 && k < 12) ? 32'(2) : 32'(1)));
            check($sformatf("pause_tick_k%0d", k), 32'(tick), 32'(k == 14));
        end

        // period 8 changed to 2 mid-interval: first interval keeps 8 cycles.
        do_reset();
        step(0, 0, 0, 0, WIDTH'(8));
        step(1, 0, 0, 0, WIDTH'(8));
        for (int k = 1; k <= 14; k++) begin
            step(0, 0, 0, 0, (k >= 3) ? WIDTH'(2) : WIDTH'(8));
            check($sformatf("pchg_tick_k%0d", k), 32'(tick), 32'(k >= 8 && (k - 8) % 2 == 0));
        end

        // Short reset pulse mid-RUN with start held high.
        do_reset();
        step(0, 0, 0, 0, WIDTH'(1));
        step(1, 0, 0, 0, WIDTH'(1));
        step(1, 0, 0, 0, WIDTH'(1));
        check("prerst_tick", 32'(tick), 32'(1));
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        check("midrst_tick", 32'(tick), 32'(0));
        check("midrst_state", 32'(state), 32'(0));
        check("midrst_running", 32'(running), 32'(0));
        #2 resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 0, WIDTH'(1));
            check($sformatf("held_start_state_k%0d", k), 32'(state), 32'(0));
            check($sformatf("held_start_tick_k%0d", k), 32'(tick), 32'(0));
        end
        step(0, 0, 0, 0, WIDTH'(1));
        step(1, 0, 0, 0, WIDTH'(1));
        check("restart_state", 32'(state), 32'(1));

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        rper = WIDTH'(3);
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(0, 2) == 0);
            rp = ($urandom_range(0, 3) == 0);
            rc = ($urandom_range(0, 30) == 0);
            re = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 15) == 0) rper = WIDTH'($urandom_range(0, 6));
            model_step(rs, rp, rc, re, int'(rper));
            exp_q.push_back({2'(m_state), m_tick});
            step(rs, rp, rc, re, rper);
            got = exp_q.pop_front();
            check("rand_state", 32'(state), 32'(got[2:1]));
            check("rand_tick", 32'(tick), 32'(got[0]));
            check("rand_running", 32'(running), 32'(got[2:1] == 2'd1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
